// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: turns one register read/write request
// into a 64-bit MDC/MDIO frame and reports completion with read data and a TA error.
module mdio_master #(
   parameter int unsigned clk_divider = 25
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_phy_addr,
   input  logic [4:0]  req_reg_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_error,
   input  logic        mdio_in,
   output logic        mdc,
   output logic        mdio_out,
   output logic        mdio_enable
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SHIFT    = 2'b01,
      COMPLETE = 2'b10
   } state_e;

   localparam logic [1:0] OP_WRITE    = 2'b01;
   localparam logic [1:0] OP_READ     = 2'b10;
   localparam logic [7:0] DIV_LAST    = 8'(clk_divider - 1);
   localparam logic [5:0] LAST_BIT    = 6'd63;
   localparam logic [5:0] TA_BIT      = 6'd47;
   localparam logic [5:0] DATA_BIT    = 6'd48;
   localparam logic [5:0] RELEASE_PRE = 6'd45;

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [63:0] shift_q, shift_d;
   logic        is_read_q, is_read_d;
   logic        ta_err_q, ta_err_d;
   logic [15:0] rd_shift_q, rd_shift_d;
   logic        mdc_q, mdc_d;
   logic        mdio_out_q, mdio_out_d;
   logic        mdio_en_q, mdio_en_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [15:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;

   logic        op_legal_s;
   logic        op_write_s;
   logic [63:0] frame_s;
   logic        next_released_s;

   // Frame image captured on accept; reads carry TA/data as ones since the pad is released there.
   always_comb begin
      op_write_s = (req_op == OP_WRITE);
      op_legal_s = op_write_s || (req_op == OP_READ);
      frame_s    = {32'hFFFF_FFFF, 2'b01, req_op, req_phy_addr, req_reg_addr,
                    (op_write_s ? 2'b10 : 2'b11),
                    (op_write_s ? req_wdata : 16'hFFFF)};
      next_released_s = is_read_q && (bit_cnt_q >= RELEASE_PRE);
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         div_q        <= 8'd0;
         bit_cnt_q    <= 6'd0;
         shift_q      <= 64'd0;
         is_read_q    <= 1'b0;
         ta_err_q     <= 1'b0;
         rd_shift_q   <= 16'd0;
         mdc_q        <= 1'b0;
         mdio_out_q   <= 1'b1;
         mdio_en_q    <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 16'd0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         is_read_q    <= is_read_d;
         ta_err_q     <= ta_err_d;
         rd_shift_q   <= rd_shift_d;
         mdc_q        <= mdc_d;
         mdio_out_q   <= mdio_out_d;
         mdio_en_q    <= mdio_en_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   // Next-state logic: accept, MDC division, bit shifting, read sampling and completion.
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      is_read_d    = is_read_q;
      ta_err_d     = ta_err_q;
      rd_shift_d   = rd_shift_q;
      mdc_d        = mdc_q;
      mdio_out_d   = mdio_out_q;
      mdio_en_d    = mdio_en_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (op_legal_s) begin
                  state_d    = SHIFT;
                  div_d      = 8'd0;
                  bit_cnt_d  = 6'd0;
                  shift_d    = frame_s;
                  is_read_d  = !op_write_s;
                  ta_err_d   = 1'b0;
                  rd_shift_d = 16'd0;
                  mdc_d      = 1'b0;
                  mdio_out_d = frame_s[63];
                  mdio_en_d  = 1'b1;
               end else begin
                  state_d      = COMPLETE;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end

         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (!mdc_q) begin
                  mdc_d = 1'b1;
               end else begin
                  // Last high cycle of the bit: the PHY's value is settled here.
                  if (is_read_q && (bit_cnt_q == TA_BIT)) begin
                     ta_err_d = mdio_in;
                  end else if (is_read_q && (bit_cnt_q >= DATA_BIT)) begin
                     rd_shift_d = {rd_shift_q[14:0], mdio_in};
                  end else begin
                     rd_shift_d = rd_shift_q;
                  end

                  mdc_d = 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d      = COMPLETE;
                     mdio_out_d   = 1'b1;
                     mdio_en_d    = 1'b0;
                     resp_valid_d = 1'b1;
                     if (is_read_q) begin
                        resp_rdata_d = {rd_shift_q[14:0], mdio_in};
                        resp_error_d = ta_err_q;
                     end else begin
                        resp_error_d = 1'b0;
                     end
                  end else begin
                     bit_cnt_d  = bit_cnt_q + 6'd1;
                     shift_d    = {shift_q[62:0], 1'b0};
                     mdio_en_d  = !next_released_s;
                     mdio_out_d = next_released_s ? 1'b1 : shift_q[62];
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         COMPLETE: begin
            state_d    = IDLE;
            mdc_d      = 1'b0;
            mdio_out_d = 1'b1;
            mdio_en_d  = 1'b0;
         end

         default: begin
            state_d    = IDLE;
            mdc_d      = 1'b0;
            mdio_out_d = 1'b1;
            mdio_en_d  = 1'b0;
         end
      endcase

      req_ready_d = (state_d == IDLE);
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_error  = resp_error_q;
   assign mdc         = mdc_q;
   assign mdio_out    = mdio_out_q;
   assign mdio_enable = mdio_en_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed table-driven bench for mdio_master at clk_divider=2 (4 clk per MDC bit).
module tb_mdio_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [4:0]  req_phy_addr;
   logic [4:0]  req_reg_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_error;
   logic        mdio_in;
   logic        mdc;
   logic        mdio_out;
   logic        mdio_enable;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   mdio_master #(.clk_divider(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mdio_in(mdio_in), .mdc(mdc), .mdio_out(mdio_out), .mdio_enable(mdio_enable)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] wdata;
      logic        phy_ta;
      logic [15:0] phy_data;
      logic [63:0] exp_frame;
      logic [63:0] exp_en;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          guard;
      int          mdc_bad;
      int          glitch;
      int          early;
      logic        o0;
      logic        e0;
      logic [63:0] cap_out;
      logic [63:0] cap_en;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
      req_valid    = 1'b1;
      req_op       = v.op;
      req_phy_addr = v.phy;
      req_reg_addr = v.regad;
      req_wdata    = v.wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (v.op == 2'b01 || v.op == 2'b10) begin
         mdc_bad = 0; glitch = 0; early = 0;
         cap_out = 64'd0; cap_en = 64'd0;
         // A stray illegal request held during the frame must be ignored.
         req_valid = 1'b1;
         req_op    = 2'b11;
         for (int n = 0; n < 64; n++) begin
            if (n == 62) req_valid = 1'b0;
            if (n == 47)      mdio_in = v.phy_ta;
            else if (n >= 48) mdio_in = v.phy_data[63 - n];
            else              mdio_in = 1'b1;
            o0 = mdio_out;
            e0 = mdio_enable;
            for (int k = 0; k < 4; k++) begin
               if (mdc !== (k >= 2)) mdc_bad++;
               if (mdio_out !== o0 || mdio_enable !== e0) glitch++;
               if (resp_valid !== 1'b0) early++;
               if (k == 2) begin
                  cap_out[63 - n] = mdio_out;
                  cap_en[63 - n]  = mdio_enable;
               end
               @(posedge clk); #1;
            end
         end
         req_valid = 1'b0;
         mdio_in   = 1'b1;
         check({tag, "_mdc_shape"}, 64'(mdc_bad), 64'd0);
         check({tag, "_bit_stable"}, 64'(glitch), 64'd0);
         check({tag, "_no_early_resp"}, 64'(early), 64'd0);
         check({tag, "_frame"}, cap_out, v.exp_frame);
         check({tag, "_enable"}, cap_en, v.exp_en);
         check({tag, "_done_valid"}, {63'd0, resp_valid}, 64'd1);
         check({tag, "_done_pins"}, {61'd0, mdc, mdio_enable, mdio_out}, 64'd1);
      end else begin
         check({tag, "_done_valid"}, {63'd0, resp_valid}, 64'd1);
         check({tag, "_no_mdc"}, {62'd0, mdc, mdio_enable}, 64'd0);
      end
      check({tag, "_rdata"}, {48'd0, resp_rdata}, {48'd0, v.exp_rdata});
      check({tag, "_error"}, {63'd0, resp_error}, {63'd0, v.exp_err});
      check({tag, "_busy"}, {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, {62'd0, resp_valid, req_ready}, 64'd1);
      check({tag, "_rdata_hold"}, {48'd0, resp_rdata}, {48'd0, v.exp_rdata});
      check({tag, "_idle_mdc"}, {63'd0, mdc}, 64'd0);
   endtask

   initial begin
      int toggles;
      int bad_resp;
      // Expected frames: 32 preamble ones, then ST/OP/PHY/REG/TA/DATA; released read bits read back as 1.
      vecs[0] = '{2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 16'hFFFF,
                  64'hFFFF_FFFF_5082_1140, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0};
      vecs[1] = '{2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 16'h0141,
                  64'hFFFF_FFFF_618B_FFFF, 64'hFFFF_FFFF_FFFC_0000, 16'h0141, 1'b0};
      vecs[2] = '{2'b10, 5'h00, 5'h01, 16'h0000, 1'b1, 16'hFFFF,
                  64'hFFFF_FFFF_6007_FFFF, 64'hFFFF_FFFF_FFFC_0000, 16'hFFFF, 1'b1};
      vecs[3] = '{2'b01, 5'h1F, 5'h1F, 16'hA5A5, 1'b1, 16'hFFFF,
                  64'hFFFF_FFFF_5FFE_A5A5, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b0};
      vecs[4] = '{2'b10, 5'h1F, 5'h10, 16'h0000, 1'b0, 16'h8001,
                  64'hFFFF_FFFF_6FC3_FFFF, 64'hFFFF_FFFF_FFFC_0000, 16'h8001, 1'b0};
      vecs[5] = '{2'b11, 5'h02, 5'h03, 16'h1234, 1'b1, 16'hFFFF,
                  64'd0, 64'd0, 16'h8001, 1'b1};
      vecs[6] = '{2'b00, 5'h04, 5'h05, 16'h5678, 1'b1, 16'hFFFF,
                  64'd0, 64'd0, 16'h8001, 1'b1};

      reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
      req_phy_addr = 5'h00; req_reg_addr = 5'h00; req_wdata = 16'h0000; mdio_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pins", {59'd0, req_ready, mdc, mdio_enable, mdio_out, resp_valid}, 64'b10010);
      check("reset_resp", {47'd0, resp_error, resp_rdata}, 64'd0);
      #2 reset_n = 1'b1;
      toggles = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (mdc !== 1'b0 || mdio_enable !== 1'b0 || resp_valid !== 1'b0) toggles++;
      end
      check("idle_quiet", 64'(toggles), 64'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Abandon a write at bit 40 and confirm the asynchronous return to reset values.
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b01; req_phy_addr = 5'h01; req_reg_addr = 5'h00;
      req_wdata = 16'h1140;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (160) @(posedge clk);
      #1;
      check("abort_bit40", {61'd0, mdc, mdio_enable, mdio_out}, 64'b011);
      #2 reset_n = 1'b0;
      #1;
      check("abort_async_pins", {59'd0, req_ready, mdc, mdio_enable, mdio_out, resp_valid}, 64'b10010);
      check("abort_async_resp", {47'd0, resp_error, resp_rdata}, 64'd0);
      bad_resp = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0 || mdc !== 1'b0) bad_resp++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0 || mdc !== 1'b0) bad_resp++;
      end
      check("abort_no_resp", 64'(bad_resp), 64'd0);
      run_vec(vecs[0], "after_abort");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Ethernet PHY management (Clause 22 MDIO) master. Converts single register read/write requests from the board control logic into MDC/MDIO frames.
- Its mdc, mdio_out and mdio_enable outputs feed the board outputs mdio__mdc, mdio__mdio and mdio__mdio_enable. mdio_in is taken from the board input mdio.
- The pad tristate is external: the pad is driven with mdio_out while mdio_enable is high, otherwise it is high-Z.

Parameters:
- clk_divider, 25, clk cycles per MDC half-period (D). Legal range is 2..255. At clk=50MHz the default gives MDC=1MHz.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block idle and able to accept a request
- req_op  input  2  2'b01 = write, 2'b10 = read, other values are illegal
- req_phy_addr  input  5  PHY address
- req_reg_addr  input  5  register address
- req_wdata  input  16  write data
- resp_valid  output  1  single-cycle completion pulse
- resp_rdata  output  16  read data, held until the next completion
- resp_error  output  1  qualified by resp_valid
- mdio_in  input  1  MDIO pad value, already synchronised externally
- mdc  output  1  management clock
- mdio_out  output  1  MDIO drive value
- mdio_enable  output  1  MDIO output enable

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mdc=0, mdio_out=1, mdio_enable=0, state=IDLE, bit counter=0, divider=0.
- States: IDLE, SHIFT, COMPLETE.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready in cycle T. Capture op, addresses and wdata into a 64-bit shift register.
  - Go to SHIFT at T+1.
  - Inputs are ignored while req_ready=0.
- Illegal op (00/11):
  - Accepted, but no frame is generated.
  - COMPLETE in T+1, giving resp_valid=1 and resp_error=1 at T+1. resp_rdata is unchanged.
- Frame bit order (bit index n = 0..63, MSB first):
  - n 0..31: preamble, all 1s.
  - n 32..33: ST = 01.
  - n 34..35: OP.
  - n 36..40: PHYAD.
  - n 41..45: REGAD.
  - n 46..47: TA, driven as 10 for a write.
  - n 48..63: DATA, MSB first.
- Bit timing:
  - Bit n starts at cycle T+1+2Dn. mdc=0 for D cycles, then mdc=1 for D cycles.
  - mdio_out and mdio_enable change only at bit start, i.e. the mdc falling edge or the first low cycle.
  - mdc toggles when the divider reaches D-1; the divider wraps to 0.
- mdio_enable:
  - 1 for all 64 bits of a write.
  - For a read, 1 for n 0..45 and 0 for n 46..63. mdio_out=1 while released.
- Read sampling:
  - mdio_in is sampled in the last mdc-high cycle of each bit n 47..63.
  - n 47 is the TA check: a sampled 1 means no PHY response, so resp_error=1.
  - n 48..63 shift into the read data, MSB first.
- COMPLETE:
  - Entered at cycle T+1+128D.
  - mdc=0, mdio_enable=0, mdio_out=1.
  - resp_valid=1 for exactly one cycle.
  - Read: resp_rdata=captured data, resp_error=TA result.
  - Write: resp_rdata unchanged, resp_error=0.
  - Next cycle: IDLE, req_ready=1. Earliest next accept is T+2+128D.
- Back-to-back requests: each frame includes the full preamble; there is no preamble suppression.
- Reset mid-frame: all outputs return to reset values immediately. The frame is abandoned and no resp_valid is issued.
- Divider and bit counter never wrap mid-frame. The bit counter is 6 bits and terminates at 63.

Test Plan:
- Reset: hold reset_n=0, then release. Expect req_ready=1, mdc=0, mdio_enable=0, mdio_out=1, resp_valid=0, with no mdc toggles while idle.
- Write, D=2: op=01, phy=5'h01, reg=5'h00, wdata=16'h1140.
  - Capture the 64 bits on mdio_out at mdc rising edges. Expect 32×1, then 01 01 00001 00000 10, then 0001000101000000.
  - mdio_enable=1 throughout.
  - resp_valid at T+257 with resp_error=0.
- Read, D=2: op=10, phy=5'h03, reg=5'h02.
  - PHY model drives 0 at n 47, then 16'h0141.
  - mdio_enable falls at the start of n 46.
  - Expect resp_rdata=16'h0141 and resp_error=0 at T+257.
- Read, no PHY: mdio_in held at 1. Expect resp_rdata=16'hFFFF and resp_error=1.
- Illegal op=2'b11: expect resp_valid and resp_error at T+1, no mdc activity, and resp_rdata unchanged.
- Reset mid-frame: assert reset_n=0 at bit n=40 of a write. Expect outputs at reset values asynchronously and no resp_valid. A new request after release produces a full frame.
